bus_matrix_prog_decoder: RTL and testbench

BUS_MATRIX_PROG_DECODER -- requirements
Module: bus_matrix_prog_decoder

---
 rtl/bus_matrix_pkg.sv | 56 +++++
 rtl/bus_matrix_region_match.sv | 55 +++++
 rtl/bus_matrix_prog_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_bus_matrix_prog_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_matrix_pkg.sv
// -----------------------------------------------------------------------------
// bus_matrix_pkg
// Shared types and constants for the programmable bus-matrix address decoder.
//   region_cfg_t    : one programmable address region (start/end inclusive,
//                     target slave index, secure-only flag, enable).
//   cfg_field_e     : selects which part of a region a config write updates.
//   ATTR_*          : bit positions inside the attribute write word.
//   apply_cfg_write : returns a region with one field replaced by write data.
// Region addresses are held at the maximum supported width (64 bits) so the
// package stays independent of the decoder's ADDR_WIDTH parameter.
// -----------------------------------------------------------------------------
package bus_matrix_pkg;

  localparam int MAX_ADDR_W = 64;
  localparam int SLV_IDX_W  = 4;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] start;
    logic [MAX_ADDR_W-1:0] end_addr;
    logic [SLV_IDX_W-1:0]  slave_idx;
    logic                  secure;
    logic                  enable;
  } region_cfg_t;

  typedef enum logic [1:0] {
    CFG_FIELD_START = 2'd0,
    CFG_FIELD_END   = 2'd1,
    CFG_FIELD_ATTR  = 2'd2,
    CFG_FIELD_RSVD  = 2'd3
  } cfg_field_e;

  localparam int ATTR_EN_BIT  = 0;
  localparam int ATTR_SEC_BIT = 1;
  localparam int ATTR_SLV_LSB = 2;
  localparam int ATTR_SLV_MSB = 5;

  // Replace the selected field of a region; the reserved field leaves it intact.
  function automatic region_cfg_t apply_cfg_write(input region_cfg_t cur,
                                                  input cfg_field_e  field,
                                                  input logic [MAX_ADDR_W-1:0] wdata);
    region_cfg_t nxt;
    nxt = cur;
    case (field)
      CFG_FIELD_START: nxt.start    = wdata;
      CFG_FIELD_END:   nxt.end_addr = wdata;
      CFG_FIELD_ATTR: begin
        nxt.enable    = wdata[ATTR_EN_BIT];
        nxt.secure    = wdata[ATTR_SEC_BIT];
        nxt.slave_idx = wdata[ATTR_SLV_MSB:ATTR_SLV_LSB];
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bus_matrix_region_match.sv
// -----------------------------------------------------------------------------
// bus_matrix_region_match
// Purely combinational priority match of one address against the region table.
// A region matches when enabled and start <= addr <= end (unsigned). A region
// with start > end can never satisfy both bounds, so it never matches.
// The lowest-numbered matching region wins.
// Ports:
//   i_table     : region table (N_REGIONS entries)
//   i_addr      : address to decode
//   o_hit       : at least one region matched
//   o_slave_idx : slave index of the winning region
//   o_secure    : secure-only flag of the winning region
// -----------------------------------------------------------------------------
module bus_matrix_region_match
  import bus_matrix_pkg::*;
#(
  parameter int N_REGIONS  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  region_cfg_t [N_REGIONS-1:0] i_table,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  output logic                        o_hit,
  output logic [SLV_IDX_W-1:0]        o_slave_idx,
  output logic                        o_secure
);

  logic [MAX_ADDR_W-1:0] w_addr_ext;
  logic [N_REGIONS-1:0]  w_match;

  // Compare at full region width so the stored upper bits still take part.
  assign w_addr_ext = MAX_ADDR_W'(i_addr);

  // Per-region inclusive bound check.
  always_comb begin
    w_match = {N_REGIONS{1'b0}};
    for (int i = 0; i < N_REGIONS; i++) begin
      w_match[i] = i_table[i].enable &&
                   (i_table[i].start <= w_addr_ext) &&
                   (w_addr_ext <= i_table[i].end_addr);
    end
  end

  // Scan from the top down so the lowest matching index overwrites the rest.
  always_comb begin
    o_hit       = 1'b0;
    o_slave_idx = {SLV_IDX_W{1'b0}};
    o_secure    = 1'b0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      o_hit       = o_hit | w_match[i];
      o_slave_idx = w_match[i] ? i_table[i].slave_idx : o_slave_idx;
      o_secure    = w_match[i] ? i_table[i].secure    : o_secure;
    end
  end

endmodule

// File: rtl/bus_matrix_prog_decoder.sv
// -----------------------------------------------------------------------------
// bus_matrix_prog_decoder
// Programmable address decoder for a bus matrix. Each accepted request is
// decoded against a register-held region table and the one-hot slave select
// (or a decode/security error) is presented one cycle later on a
// valid/ready response channel. Error responses are logged (first address and
// type, saturating count). The region table is writable field by field until
// the lock bit is set.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   req_valid_i/req_ready_o       : request handshake, req_addr_i, req_secure_i
//   rsp_valid_o/rsp_ready_i       : response handshake
//   rsp_slave_sel_o               : one-hot target, zero on error
//   rsp_dec_err_o, rsp_sec_err_o  : decode miss / security violation
//   cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i : region table write port
//   cfg_lock_i                    : sets the sticky lock bit
//   cfg_err_o                     : one-cycle pulse for a rejected write
//   err_valid_o, err_addr_o, err_type_o, err_count_o, err_clr_i : error log
// -----------------------------------------------------------------------------
module bus_matrix_prog_decoder
  import bus_matrix_pkg::*;
#(
  parameter int                          M_SLAVES            = 4,
  parameter int                          ADDR_WIDTH          = 32,
  parameter int                          N_REGIONS           = 8,
  parameter region_cfg_t [N_REGIONS-1:0] RESET_MAP           = '0,
  parameter int                          USE_DEFAULT_SLAVE   = 0,
  parameter int                          DEFAULT_SLAVE_INDEX = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_secure_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [M_SLAVES-1:0]   rsp_slave_sel_o,
  output logic                  rsp_dec_err_o,
  output logic                  rsp_sec_err_o,
  input  logic                  cfg_we_i,
  input  logic [((N_REGIONS > 1) ? $clog2(N_REGIONS) : 1)-1:0] cfg_idx_i,
  input  logic [1:0]            cfg_field_i,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata_i,
  input  logic                  cfg_lock_i,
  output logic                  cfg_err_o,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_type_o,
  output logic [7:0]            err_count_o,
  input  logic                  err_clr_i
);

  localparam int IDX_W     = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int IDX_SPACE = 1 << IDX_W;
  // Table lookups instead of magnitude compares: bit k set when index k exists.
  localparam logic [IDX_SPACE-1:0] IDX_VALID_MASK = IDX_SPACE'((64'd1 << N_REGIONS) - 64'd1);
  localparam logic [15:0]          SLV_VALID_MASK = 16'((32'd1 << M_SLAVES) - 32'd1);
  localparam logic [M_SLAVES-1:0]  SEL_ONE        = M_SLAVES'(1'b1);

  region_cfg_t [N_REGIONS-1:0] r_table;
  logic                  r_lock;
  logic                  r_cfg_err;
  logic                  r_rsp_valid;
  logic [M_SLAVES-1:0]   r_rsp_sel;
  logic                  r_rsp_dec_err;
  logic                  r_rsp_sec_err;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic                  r_err_valid;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_type;
  logic [7:0]            r_err_count;

  logic                  w_hit;
  logic [SLV_IDX_W-1:0]  w_win_slave;
  logic                  w_win_secure;
  logic [M_SLAVES-1:0]   w_sel;
  logic                  w_dec_err;
  logic                  w_sec_err;
  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic                  w_err_fire;
  logic                  w_cfg_bad;
  logic                  w_cfg_wr;
  logic                  w_cfg_reject;

  bus_matrix_region_match #(
    .N_REGIONS  (N_REGIONS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_match (
    .i_table     (r_table),
    .i_addr      (req_addr_i),
    .o_hit       (w_hit),
    .o_slave_idx (w_win_slave),
    .o_secure    (w_win_secure)
  );

  // The response register empties whenever the consumer takes it, so a new
  // request can be accepted in the same cycle (full throughput).
  assign req_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_req_fire  = req_valid_i && req_ready_o;
  assign w_rsp_fire  = r_rsp_valid && rsp_ready_i;
  assign w_err_fire  = w_rsp_fire && (r_rsp_dec_err || r_rsp_sec_err);

  // Config write qualification: out-of-range index, reserved field or lock.
  assign w_cfg_bad    = !IDX_VALID_MASK[cfg_idx_i] || (cfg_field_i == 2'd3);
  assign w_cfg_wr     = cfg_we_i && !r_lock && !w_cfg_bad;
  assign w_cfg_reject = cfg_we_i && (r_lock || w_cfg_bad);

  // Turn the match result into select/error; security is checked before index range.
  always_comb begin
    w_sel     = {M_SLAVES{1'b0}};
    w_dec_err = 1'b0;
    w_sec_err = 1'b0;
    if (w_hit) begin
      if (w_win_secure && !req_secure_i) begin
        w_sec_err = 1'b1;
      end else if (!SLV_VALID_MASK[w_win_slave]) begin
        w_dec_err = 1'b1;
      end else begin
        w_sel = SEL_ONE << w_win_slave;
      end
    end else if (USE_DEFAULT_SLAVE != 0) begin
      if (DEFAULT_SLAVE_INDEX < M_SLAVES) begin
        w_sel = SEL_ONE << DEFAULT_SLAVE_INDEX;
      end else begin
        w_dec_err = 1'b1;
      end
    end else begin
      w_dec_err = 1'b1;
    end
  end

  // Region table: decode above always sees the pre-write contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_table <= RESET_MAP;
    end else if (w_cfg_wr) begin
      r_table[cfg_idx_i] <= apply_cfg_write(r_table[cfg_idx_i], cfg_field_e'(cfg_field_i),
                                            MAX_ADDR_W'(cfg_wdata_i));
    end
  end

  // Sticky lock bit and rejected-write pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_lock    <= r_lock | cfg_lock_i;
      r_cfg_err <= w_cfg_reject;
    end
  end

  // Response register: load on accept, hold under back-pressure, drop when taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_sel     <= {M_SLAVES{1'b0}};
      r_rsp_dec_err <= 1'b0;
      r_rsp_sec_err <= 1'b0;
      r_rsp_addr    <= {ADDR_WIDTH{1'b0}};
    end else if (w_req_fire) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_sel     <= w_sel;
      r_rsp_dec_err <= w_dec_err;
      r_rsp_sec_err <= w_sec_err;
      r_rsp_addr    <= req_addr_i;
    end else if (rsp_ready_i) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  // Error log: clear wins over capture; count saturates at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= {ADDR_WIDTH{1'b0}};
      r_err_type  <= 1'b0;
      r_err_count <= 8'd0;
    end else if (err_clr_i) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= {ADDR_WIDTH{1'b0}};
      r_err_type  <= 1'b0;
      r_err_count <= 8'd0;
    end else if (w_err_fire) begin
      if (!r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= r_rsp_addr;
        r_err_type  <= r_rsp_sec_err;
      end
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_slave_sel_o = r_rsp_sel;
  assign rsp_dec_err_o   = r_rsp_dec_err;
  assign rsp_sec_err_o   = r_rsp_sec_err;
  assign cfg_err_o       = r_cfg_err;
  assign err_valid_o     = r_err_valid;
  assign err_addr_o      = r_err_addr;
  assign err_type_o      = r_err_type;
  assign err_count_o     = r_err_count;

endmodule

// File: tb/tb_bus_matrix_prog_decoder.sv
// -----------------------------------------------------------------------------
// tb_bus_matrix_prog_decoder
// Self-checking bench: a behavioural model (region arrays, response queue,
// error-log variables) is stepped once per cycle alongside the DUT, with a
// table of reset-map vectors, directed corner-case sequences and a randomized
// phase. N_REGIONS is 6 so an out-of-range region index is expressible.
// -----------------------------------------------------------------------------
module tb_bus_matrix_prog_decoder;
  import bus_matrix_pkg::*;

  localparam int NR = 6;
  localparam int M  = 4;
  localparam int AW = 32;

  localparam region_cfg_t R0_INIT = '{start: 64'h1000, end_addr: 64'h1FFF,
                                      slave_idx: 4'd1, secure: 1'b0, enable: 1'b1};
  localparam region_cfg_t R1_INIT = '{start: 64'h0, end_addr: 64'hFFFF,
                                      slave_idx: 4'd0, secure: 1'b0, enable: 1'b1};
  localparam region_cfg_t RZ = '0;
  localparam region_cfg_t [NR-1:0] TB_MAP = {RZ, RZ, RZ, RZ, R1_INIT, R0_INIT};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_secure = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0, cfg_wdata = '0;
  logic          cfg_we = 1'b0, cfg_lock = 1'b0, err_clr = 1'b0;
  logic [2:0]    cfg_idx = '0;
  logic [1:0]    cfg_field = '0;
  logic          req_ready, rsp_valid, rsp_dec, rsp_sec, cfg_err, err_valid, err_type;
  logic [M-1:0]  rsp_sel;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_count;

  bus_matrix_prog_decoder #(
    .M_SLAVES(M), .ADDR_WIDTH(AW), .N_REGIONS(NR), .RESET_MAP(TB_MAP),
    .USE_DEFAULT_SLAVE(0), .DEFAULT_SLAVE_INDEX(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_secure_i(req_secure),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_slave_sel_o(rsp_sel), .rsp_dec_err_o(rsp_dec), .rsp_sec_err_o(rsp_sec),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_lock_i(cfg_lock), .cfg_err_o(cfg_err),
    .err_valid_o(err_valid), .err_addr_o(err_addr), .err_type_o(err_type),
    .err_count_o(err_count), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [M-1:0]  sel;
    logic          dec;
    logic          sec;
    logic [AW-1:0] addr;
  } exp_t;

  logic [AW-1:0] m_start [NR];
  logic [AW-1:0] m_end   [NR];
  logic [3:0]    m_slv   [NR];
  bit            m_sec   [NR];
  bit            m_en    [NR];
  bit            m_lock, m_cfg_err, m_err_valid, m_err_type;
  logic [AW-1:0] m_err_addr;
  int            m_err_count;
  exp_t          q[$];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_start[i] = '0; m_end[i] = '0; m_slv[i] = '0; m_sec[i] = 0; m_en[i] = 0;
    end
    m_start[0] = 32'h1000; m_end[0] = 32'h1FFF; m_slv[0] = 4'd1; m_en[0] = 1;
    m_start[1] = 32'h0000; m_end[1] = 32'hFFFF; m_slv[1] = 4'd0; m_en[1] = 1;
    m_lock = 0; m_cfg_err = 0;
    m_err_valid = 0; m_err_type = 0; m_err_addr = '0; m_err_count = 0;
    q.delete();
  endtask

  function automatic exp_t mdl_decode(input logic [AW-1:0] a, input bit s);
    exp_t r;
    int   w;
    r = '0; r.addr = a; w = -1;
    for (int i = 0; i < NR; i++)
      if (w < 0 && m_en[i] && m_start[i] <= a && a <= m_end[i]) w = i;
    if (w < 0)                    r.dec = 1'b1;
    else if (m_sec[w] && !s)      r.sec = 1'b1;
    else if (int'(m_slv[w]) >= M) r.dec = 1'b1;
    else                          r.sel = 4'b0001 << m_slv[w];
    return r;
  endfunction

  // One clock cycle: check the pre-edge outputs, advance the model, check after the edge.
  task automatic cyc();
    bit   exp_ready, hs_req, hs_rsp;
    exp_t e;
    #1;
    exp_ready = (q.size() == 0) || rsp_ready;
    chk("req_ready", req_ready, exp_ready);
    if (q.size() > 0) begin
      chk("rsp_sel", rsp_sel, q[0].sel);
      chk("rsp_dec_err", rsp_dec, q[0].dec);
      chk("rsp_sec_err", rsp_sec, q[0].sec);
    end
    hs_rsp = (q.size() > 0) && rsp_ready;
    hs_req = req_valid && exp_ready;
    e = mdl_decode(req_addr, req_secure);
    if (err_clr) begin
      m_err_valid = 0; m_err_addr = '0; m_err_type = 0; m_err_count = 0;
    end else if (hs_rsp && (q[0].dec || q[0].sec)) begin
      if (!m_err_valid) begin
        m_err_valid = 1; m_err_addr = q[0].addr; m_err_type = q[0].sec;
      end
      if (m_err_count < 255) m_err_count++;
    end
    if (hs_rsp) void'(q.pop_front());
    if (hs_req) q.push_back(e);
    m_cfg_err = 0;
    if (cfg_we) begin
      if (m_lock || int'(cfg_idx) >= NR || cfg_field == 2'd3) m_cfg_err = 1;
      else if (cfg_field == 2'd0) m_start[cfg_idx] = cfg_wdata;
      else if (cfg_field == 2'd1) m_end[cfg_idx] = cfg_wdata;
      else begin
        m_en[cfg_idx] = cfg_wdata[0]; m_sec[cfg_idx] = cfg_wdata[1];
        m_slv[cfg_idx] = cfg_wdata[5:2];
      end
    end
    if (cfg_lock) m_lock = 1;
    @(posedge clk);
    #1;
    chk("rsp_valid", rsp_valid, q.size() > 0);
    chk("cfg_err", cfg_err, m_cfg_err);
    chk("err_valid", err_valid, m_err_valid);
    chk("err_addr", err_addr, m_err_addr);
    chk("err_type", err_type, m_err_type);
    chk("err_count", err_count, 64'(m_err_count));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    bit            sec;
    logic [M-1:0]  sel;
    bit            dec;
    bit            serr;
  } vec_t;
  vec_t vecs[8];

  logic [AW-1:0] bp_addr [4];
  logic [M-1:0]  bp_sel  [4];

  initial begin
    vecs[0] = '{32'h0000_1800, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_1000, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_1FFF, 1'b1, 4'b0010, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0FFF, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_2000, 1'b0, 4'b0001, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_FFFF, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[6] = '{32'h0001_0000, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b1, 1'b0};
    bp_addr[0] = 32'h1800; bp_addr[1] = 32'h2000; bp_addr[2] = 32'h3000; bp_addr[3] = 32'h1100;
    bp_sel[0]  = 4'b0010;  bp_sel[1]  = 4'b0001;  bp_sel[2]  = 4'b0001;  bp_sel[3]  = 4'b0010;

    // Reset state, including ready held high while in reset.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_sel", rsp_sel, 4'b0000);
    chk("rst_dec", rsp_dec, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    rst_n = 1'b1;

    // Reset-map vectors with one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = vecs[i].addr; req_secure = vecs[i].sec;
      cyc();
      req_valid = 1'b0;
      chk("vec_valid", rsp_valid, 1'b1);
      chk("vec_sel", rsp_sel, vecs[i].sel);
      chk("vec_dec", rsp_dec, vecs[i].dec);
      chk("vec_sec", rsp_sec, vecs[i].serr);
      cyc();
    end

    // R0 secure; non-secure access logs a security error.
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_field = 2'd2; cfg_wdata = 32'h7; err_clr = 1'b1;
    cyc();
    cfg_we = 1'b0; err_clr = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1004; req_secure = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("sec_err", rsp_sec, 1'b1);
    chk("sec_sel", rsp_sel, 4'b0000);
    cyc();
    chk("sec_log_addr", err_addr, 32'h1004);
    chk("sec_log_type", err_type, 1'b1);
    chk("sec_log_count", err_count, 8'd1);
    req_valid = 1'b1; req_secure = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("sec_ok_sel", rsp_sel, 4'b0010);
    cyc();

    // Back-pressure: three stalled cycles, then one response per cycle.
    rsp_ready = 1'b0; req_valid = 1'b1; req_secure = 1'b1; req_addr = bp_addr[0];
    cyc();
    req_addr = bp_addr[1];
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_ready_low", req_ready, 1'b0);
      chk("bp_hold_sel", rsp_sel, bp_sel[0]);
      chk("bp_hold_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      req_addr = bp_addr[j];
      cyc();
      chk("bp_stream_sel", rsp_sel, bp_sel[j]);
    end
    req_valid = 1'b0;
    cyc();

    // Same-cycle write does not affect the decode, then start>end region.
    req_valid = 1'b1; req_addr = 32'h1000; req_secure = 1'b1;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_field = 2'd1; cfg_wdata = 32'h0FFF;
    cyc();
    cfg_we = 1'b0;
    chk("same_cycle_sel", rsp_sel, 4'b0010);
    cyc();
    chk("inverted_r0_sel", rsp_sel, 4'b0001);
    req_addr = 32'h20000;
    cyc();
    chk("nomatch_dec", rsp_dec, 1'b1);
    req_valid = 1'b0;
    cyc();

    // Rejected writes: bad index, reserved field, then locked.
    cfg_we = 1'b1; cfg_idx = 3'd6; cfg_field = 2'd0; cfg_wdata = 32'h0;
    cyc();
    cfg_we = 1'b0;
    chk("bad_idx_pulse", cfg_err, 1'b1);
    cyc();
    chk("pulse_one_cycle", cfg_err, 1'b0);
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_field = 2'd3;
    cyc();
    cfg_we = 1'b0;
    chk("rsvd_field_pulse", cfg_err, 1'b1);
    cfg_lock = 1'b1;
    cyc();
    cfg_lock = 1'b0;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_field = 2'd0; cfg_wdata = 32'h0;
    cyc();
    cfg_we = 1'b0;
    chk("locked_pulse", cfg_err, 1'b1);
    req_valid = 1'b1; req_addr = 32'h0800; req_secure = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("locked_map_sel", rsp_sel, 4'b0001);
    cyc();

    // Counter saturation, then clear coincident with an error handshake.
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    req_valid = 1'b1; req_addr = 32'h20000; req_secure = 1'b0;
    repeat (300) cyc();
    req_valid = 1'b0;
    cyc();
    chk("sat_count", err_count, 8'd255);
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_prio_count", err_count, 8'd0);
    chk("clr_prio_valid", err_valid, 1'b0);

    // Reset with a response pending: dropped, map and lock restored.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h1800; req_secure = 1'b0;
    cyc();
    req_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_sel", rsp_sel, 4'b0000);
    chk("mid_rst_ready", req_ready, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_ready", req_ready, 1'b1);
    rst_n = 1'b1; rsp_ready = 1'b1;
    cyc();
    chk("no_replay", rsp_valid, 1'b0);
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("post_rst_map", rsp_sel, 4'b0010);
    cyc();

    // Randomized traffic and config against the model.
    for (int n = 0; n < 800; n++) begin
      req_valid  = ($urandom % 4) != 0;
      req_addr   = $urandom_range(0, 32'h1_FFFF);
      req_secure = $urandom % 2;
      rsp_ready  = ($urandom % 3) != 0;
      cfg_we     = ($urandom % 6) == 0;
      cfg_idx    = 3'($urandom_range(0, 7));
      cfg_field  = 2'($urandom % 4);
      cfg_wdata  = (cfg_field == 2'd2) ? 32'($urandom % 64) : 32'($urandom_range(0, 32'h1_FFFF));
      cfg_lock   = ($urandom % 400) == 0;
      err_clr    = ($urandom % 60) == 0;
      cyc();
    end
    req_valid = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0; err_clr = 1'b0; rsp_ready = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
